carry_chain_pipe: RTL

CARRY_CHAIN_PIPE -- requirements
Module: carry_chain_pipe

---
 rtl/carry_chain_pkg.sv | 32 +++
 rtl/carry_chain_seg.sv | 26 ++
 rtl/carry_chain_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/carry_chain_pkg.sv
// carry_chain_pkg: shared constants, segment-count helper and the pipeline
// stage record used by carry_chain_pipe.
package carry_chain_pkg;

    // Legal range of the total chain width.
    localparam int MIN_WIDTH = 8;
    localparam int MAX_WIDTH = 128;

    // One pipeline stage. The data field holds two lanes of MAX_WIDTH bits:
    //   lane A = data[MAX_WIDTH-1:0]             : DI for segments not yet
    //                                              computed, CO for segments done
    //   lane B = data[2*MAX_WIDTH-1:MAX_WIDTH]   : S  for segments not yet
    //                                              computed, O  for segments done
    // Keeping unconsumed inputs and finished outputs in the same slots is what
    // provides the input skew and output deskew. Lane bits at or above WIDTH
    // stay zero.
    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic [2*MAX_WIDTH-1:0]   data;
    } stage_t;

    // Number of pipeline segments; guards against a zero segment width so the
    // range checks in the top can report the problem instead of dividing by 0.
    function automatic int calc_nseg(input int width, input int seg_w);
        if (seg_w > 0) begin
            return width / seg_w;
        end
        return 1;
    endfunction

endpackage

// File: rtl/carry_chain_seg.sv
// carry_chain_seg: one purely combinational SEG_W-bit carry-mux/XOR chain.
// Bit i: o = s ^ c, co = s ? c : di, and co feeds the next bit's carry.
module carry_chain_seg #(
    parameter int SEG_W = 8
) (
    input  logic             ci,
    input  logic [SEG_W-1:0] di,
    input  logic [SEG_W-1:0] s,
    output logic [SEG_W-1:0] co,
    output logic [SEG_W-1:0] o
);

    // Ripple the carry through the segment, bit 0 first.
    always_comb begin
        logic c;
        c  = ci;
        co = '0;
        o  = '0;
        for (int i = 0; i < SEG_W; i++) begin
            o[i]  = s[i] ^ c;
            co[i] = s[i] ? c : di[i];
            c     = co[i];
        end
    end

endmodule

// File: rtl/carry_chain_pipe.sv
// carry_chain_pipe: WIDTH-bit carry-mux chain split into NSEG = WIDTH/SEG_W
// pipeline segments. Segment k is evaluated in stage k; its carry-out is
// registered into stage k+1, so a beat's CO/O emerge aligned NSEG cycles
// after acceptance.
// Build option: define CARRY_CHAIN_PIPE_SPLIT_EN to add the SPLIT/CI_SEG
// ports, which let segment k>0 take CI_SEG[k] as its carry-in.
//
// Handshake: a beat transfers on a rising CLK edge where VALID and READY are
// both high on that side. IN_VALID/OUT_VALID must not depend on the matching
// READY. The whole pipeline advances on an edge where OUT_VALID is low or
// OUT_READY is high; IN_READY is exactly that advance condition, so it is
// combinational on OUT_READY. A pop and a push may happen on the same edge.
module carry_chain_pipe
    import carry_chain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             CI,
    input  logic [WIDTH-1:0] DI,
    input  logic [WIDTH-1:0] S,
`ifdef CARRY_CHAIN_PIPE_SPLIT_EN
    input  logic [calc_nseg(WIDTH, SEG_W)-1:0] SPLIT,
    input  logic [calc_nseg(WIDTH, SEG_W)-1:0] CI_SEG,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] CO,
    output logic [WIDTH-1:0] O
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_seg_w
        $error("carry_chain_pipe: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
    end
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("carry_chain_pipe: WIDTH (%0d) outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
    end

    logic              advance;
    stage_t [NSEG-1:0] pipe_q;
    stage_t [NSEG-1:0] stage_d;
    logic [NSEG-1:0]   seg_cin;
    logic [WIDTH-1:0]  seg_co;
    logic [WIDTH-1:0]  seg_o;
    logic [WIDTH-1:0]  res_co;
    logic [WIDTH-1:0]  res_o;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

`ifdef CARRY_CHAIN_PIPE_SPLIT_EN
    // Split controls travel with the beat: [stage][segment].
    logic [NSEG-1:0][NSEG-1:0] split_q;
    logic [NSEG-1:0][NSEG-1:0] ci_seg_q;

    // Shift the split controls alongside the stage records.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            split_q  <= '0;
            ci_seg_q <= '0;
        end else if (advance) begin
            split_q[0]  <= SPLIT;
            ci_seg_q[0] <= CI_SEG;
            for (int k = 1; k < NSEG; k++) begin
                split_q[k]  <= split_q[k-1];
                ci_seg_q[k] <= ci_seg_q[k-1];
            end
        end
    end
`endif

    // Carry into each segment: the registered carry from the previous
    // segment, or the injected carry when that segment is split off.
    always_comb begin
        seg_cin = '0;
        for (int k = 0; k < NSEG; k++) begin
            seg_cin[k] = pipe_q[k].carry;
        end
`ifdef CARRY_CHAIN_PIPE_SPLIT_EN
        for (int k = 1; k < NSEG; k++) begin
            if (split_q[k][k]) begin
                seg_cin[k] = ci_seg_q[k][k];
            end
        end
`endif
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        carry_chain_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .ci (seg_cin[k]),
            .di (pipe_q[k].data[k*SEG_W +: SEG_W]),
            .s  (pipe_q[k].data[MAX_WIDTH + k*SEG_W +: SEG_W]),
            .co (seg_co[k*SEG_W +: SEG_W]),
            .o  (seg_o[k*SEG_W +: SEG_W])
        );
    end

    // Next stage contents: stage 0 loads the new beat; stage k takes stage
    // k-1 with segment k-1's inputs replaced by its results and its carry-out.
    always_comb begin
        stage_d                         = '0;
        stage_d[0].valid                = IN_VALID;
        stage_d[0].carry                = CI;
        stage_d[0].data[WIDTH-1:0]      = DI;
        stage_d[0].data[MAX_WIDTH +: WIDTH] = S;
        for (int k = 1; k < NSEG; k++) begin
            stage_d[k]       = pipe_q[k-1];
            stage_d[k].carry = seg_co[k*SEG_W-1];
            stage_d[k].data[(k-1)*SEG_W +: SEG_W]             = seg_co[(k-1)*SEG_W +: SEG_W];
            stage_d[k].data[MAX_WIDTH + (k-1)*SEG_W +: SEG_W] = seg_o[(k-1)*SEG_W +: SEG_W];
        end
    end

    // Final result: earlier segments come from the last stage record, the
    // top segment straight from its combinational chain.
    always_comb begin
        res_co = pipe_q[NSEG-1].data[WIDTH-1:0];
        res_o  = pipe_q[NSEG-1].data[MAX_WIDTH +: WIDTH];
        res_co[(NSEG-1)*SEG_W +: SEG_W] = seg_co[(NSEG-1)*SEG_W +: SEG_W];
        res_o[(NSEG-1)*SEG_W +: SEG_W]  = seg_o[(NSEG-1)*SEG_W +: SEG_W];
    end

    // Stage registers and output register; everything freezes while stalled,
    // and CO/O only change when a valid beat reaches the output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pipe_q    <= '0;
            OUT_VALID <= 1'b0;
            CO        <= '0;
            O         <= '0;
        end else if (advance) begin
            pipe_q    <= stage_d;
            OUT_VALID <= pipe_q[NSEG-1].valid;
            if (pipe_q[NSEG-1].valid) begin
                CO <= res_co;
                O  <= res_o;
            end
        end
    end

    // Lane bits above WIDTH and already-consumed split controls are never
    // read by the datapath; fold them into one sink.
    logic unused_bits;
`ifdef CARRY_CHAIN_PIPE_SPLIT_EN
    assign unused_bits = ^{pipe_q, split_q, ci_seg_q};
`else
    assign unused_bits = ^pipe_q;
`endif

endmodule
